rf_write_sequencer: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/rf_write_sequencer.sv | 97 +++++++++
 tb/tb_rf_write_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register file constants and the write-queue entry type.
// The register file and the hazard unit use the same definitions.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int REG_W = 32;

  typedef struct packed {
    logic [3:0]       dest;
    logic [REG_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write queue. One request can push two entries in a cycle, and
// one entry is popped per cycle. The queue exposes every slot plus an
// occupancy mask, so the parent can build the pending-register mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push0,
  input  wb_entry_t        i_entry0,
  input  logic             i_push1,
  input  wb_entry_t        i_entry1,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic [CW-1:0]    o_count,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_occupied
);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_next;

  assign w_wr_next = r_wr_ptr + AW'(1);

  // The storage array is not reset. A slot is only meaningful while the
  // counter covers it, so stale data after a reset is harmless.
  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[r_wr_ptr] <= i_entry0;
    if (i_push1) r_mem[w_wr_next] <= i_entry1;
  end

  // Pointer and occupancy bookkeeping. The push count can be 0..2 and the
  // pop count 0..1 in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    o_occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[i];
      o_occupied[i] = ({1'b0, AW'(i) - r_rd_ptr} < r_count);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rf_write_sequencer.sv
// Serializes writeback requests (destination plus optional base-register
// writeback) onto the register file's single write port, one write per
// clock. It also publishes a mask of registers that still have writes in
// flight.
module rf_write_sequencer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_rd,
  input  logic [REG_W-1:0]        req_data,
  input  logic                    req_wb,
  input  logic [3:0]              req_rn,
  input  logic [REG_W-1:0]        req_rn_data,
  input  logic                    hold,
  output logic [3:0]              C,
  output logic [REG_W-1:0]        PW,
  output logic                    RFLd,
  output logic                    PCLd,
  output logic [NUM_REGS-1:0]     pending,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             w_accept;
  logic             w_dual;
  logic             w_pop;
  wb_entry_t        w_entry0;
  wb_entry_t        w_entry1;
  wb_entry_t        w_head;
  logic [CW-1:0]    w_count;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_occupied;

  // Two free slots are required so a dual-write request always fits.
  assign req_ready = (w_count <= CW'(DEPTH - 2));
  assign w_accept  = req_valid & req_ready;

  // When the base register equals the destination, the load result wins.
  // In that case only one entry is pushed.
  assign w_dual = req_wb & (req_rn != req_rd);

  // The base write goes in first, so the primary write lands last.
  always_comb begin
    if (w_dual) w_entry0 = '{dest: req_rn, data: req_rn_data};
    else        w_entry0 = '{dest: req_rd, data: req_data};
    w_entry1 = '{dest: req_rd, data: req_data};
  end

  assign w_pop = (w_count != '0) & ~hold;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_push0    (w_accept),
    .i_entry0   (w_entry0),
    .i_push1    (w_accept & w_dual),
    .i_entry1   (w_entry1),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_entries  (w_entries),
    .o_occupied (w_occupied)
  );

  // Write port: the head entry is shown while it is being popped.
  // Otherwise the port is driven to zero.
  always_comb begin
    C    = '0;
    PW   = '0;
    RFLd = 1'b0;
    PCLd = 1'b0;
    if (w_pop) begin
      C    = w_head.dest;
      PW   = w_head.data;
      RFLd = 1'b1;
      PCLd = (w_head.dest == REG_PC);
    end
  end

  // Pending mask: the OR of the one-hot destinations of all occupied
  // slots, including the head.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occupied[i]) pending[w_entries[i].dest] = 1'b1;
    end
  end

  assign count = w_count;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer. A queue-based reference model is checked
// every cycle. Stimulus is directed scenarios followed by random traffic.
module tb_rf_write_sequencer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rd;
  logic [31:0] req_data;
  logic        req_wb;
  logic [3:0]  req_rn;
  logic [31:0] req_rn_data;
  logic        hold;
  logic [3:0]  C;
  logic [31:0] PW;
  logic        RFLd;
  logic        PCLd;
  logic [15:0] pending;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t model_q [$];

  rf_write_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .req_wb(req_wb), .req_rn(req_rn),
    .req_rn_data(req_rn_data), .hold(hold), .C(C), .PW(PW), .RFLd(RFLd),
    .PCLd(PCLd), .pending(pending), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compares every DUT output against what the model queue implies.
  task automatic check_model();
    logic [15:0] exp_pend;
    logic        busy;
    exp_pend = '0;
    foreach (model_q[i]) exp_pend[model_q[i].dest] = 1'b1;
    busy = (model_q.size() != 0) && !hold;
    check("ready", req_ready, (DEPTH - model_q.size()) >= 2);
    check("count", count, model_q.size());
    check("pending", pending, exp_pend);
    check("RFLd", RFLd, busy);
    check("C", C, busy ? model_q[0].dest : 4'd0);
    check("PW", PW, busy ? model_q[0].data : 32'd0);
    check("PCLd", PCLd, busy && model_q[0].dest == 4'd15);
  endtask

  // Drives one cycle, checks the outputs mid-cycle, then advances the model
  // across the rising edge.
  task automatic step(input logic v, input logic [3:0] rd, input logic [31:0] d,
                      input logic wb, input logic [3:0] rn, input logic [31:0] rnd,
                      input logic h, input logic r, output logic accepted);
    logic do_pop;
    req_valid = v; req_rd = rd; req_data = d; req_wb = wb;
    req_rn = rn; req_rn_data = rnd; hold = h; RST = r;
    #1;
    check_model();
    accepted = v && !r && ((DEPTH - model_q.size()) >= 2);
    do_pop = (model_q.size() != 0) && !h;
    @(posedge CLK);
    if (r) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (accepted) begin
        if (wb && rn != rd) model_q.push_back('{rn, rnd});
        model_q.push_back('{rd, d});
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_rd = 0; req_data = 0; req_wb = 0;
    req_rn = 0; req_rn_data = 0; hold = 0; RST = 0;
    #1;
  endtask

  initial begin
    logic acc;
    logic [3:0]  r_rd, r_rn;
    logic [31:0] r_d, r_rnd;
    logic        r_v, r_wb;

    idle_inputs();
    RST = 1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 0; #1;
    check("rst_ready", req_ready, 1);
    check("rst_count", count, 0);
    check("rst_RFLd", RFLd, 0);
    check("rst_pending", pending, 0);

    // Single write
    step(1, 3, 90, 0, 0, 0, 0, 0, acc);
    idle_inputs();
    check("single_C", C, 3);
    check("single_PW", PW, 90);
    check("single_pend", pending, 16'h0008);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Dual write
    step(1, 2, 7, 1, 5, 32'h100, 0, 0, acc);
    idle_inputs();
    check("dual_count0", count, 2);
    check("dual_C0", C, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("dual_C1", C, 2);
    check("dual_PW1", PW, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Collapse
    step(1, 4, 17, 1, 4, 99, 0, 0, acc);
    idle_inputs();
    check("collapse_count", count, 1);
    check("collapse_PW", PW, 17);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // PC write
    step(1, 15, 35, 0, 0, 0, 0, 0, acc);
    idle_inputs();
    check("pc_PCLd", PCLd, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Full with hold; the third request waits until space opens up
    step(1, 1, 11, 1, 2, 22, 1, 0, acc);
    step(1, 3, 33, 1, 6, 66, 1, 0, acc);
    check("full_count", count, 4);
    for (int i = 0; i < 2; i++) step(1, 7, 77, 0, 0, 0, 1, 0, acc);
    check("full_wait", acc, 0);
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) step(1, 7, 77, 0, 0, 0, 0, 0, acc);
    check("full_accept", acc, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Reset mid-drain
    step(1, 8, 1, 1, 9, 2, 1, 0, acc);
    step(1, 10, 3, 0, 0, 0, 0, 0, acc);
    check("pre_rst_count", count, 2);
    step(1, 11, 4, 0, 0, 0, 0, 1, acc);
    idle_inputs();
    check("post_rst_count", count, 0);
    check("post_rst_RFLd", RFLd, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Random traffic; an unaccepted request is held stable
    r_v = 0; r_rd = 0; r_d = 0; r_wb = 0; r_rn = 0; r_rnd = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!r_v) begin
        r_v = ($urandom_range(0, 1) == 1);
        r_rd = 4'($urandom_range(0, 15));
        r_d = $urandom;
        r_wb = ($urandom_range(0, 1) == 1);
        r_rn = ($urandom_range(0, 3) == 0) ? r_rd : 4'($urandom_range(0, 15));
        r_rnd = $urandom;
      end
      step(r_v, r_rd, r_d, r_wb, r_rn, r_rnd, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 63) == 0), acc);
      if (acc) r_v = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
